// File: rtl/complex_mem_port.sv
// -----------------------------------------------------------------------------
// complex_mem_port
//   Load/store engine for one complex operand. The 16-bit effective address
//   {addr_hi,addr_lo} comes from the ALU's MEM_ACCESS result. The engine moves
//   the real byte at base and the imaginary byte at base+1 (modulo 2^ADDR_SIZE)
//   as two back-to-back bus beats under a req/ack handshake.
//
//   Optional feature macro: MEM_PORT_TIMEOUT_EN
//     defined   : an 8-bit watchdog aborts a beat after 255 consecutive wait
//                 cycles; done and err then pulse together.
//     undefined : no watchdog, the engine waits for ack indefinitely, err = 0.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start, is_store    request one access (sampled in IDLE only), direction
//   addr_hi, addr_lo   base address bytes
//   wdata_re, wdata_im store data, captured with start
//   busy, done, err    status: not idle / completion pulse / timeout pulse
//   rdata_re, rdata_im loaded components, held until the next load
//   mem_req, mem_we, mem_addr, mem_wdata   registered bus request
//   mem_ack, mem_rdata                     bus response
// -----------------------------------------------------------------------------
module complex_mem_port #(
   parameter int NUMBER_SIZE = 8,
   parameter int ADDR_SIZE   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   is_store,
   input  logic [NUMBER_SIZE-1:0] addr_hi,
   input  logic [NUMBER_SIZE-1:0] addr_lo,
   input  logic [NUMBER_SIZE-1:0] wdata_re,
   input  logic [NUMBER_SIZE-1:0] wdata_im,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [NUMBER_SIZE-1:0] rdata_re,
   output logic [NUMBER_SIZE-1:0] rdata_im,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [ADDR_SIZE-1:0]   mem_addr,
   output logic [NUMBER_SIZE-1:0] mem_wdata,
   input  logic                   mem_ack,
   input  logic [NUMBER_SIZE-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BEAT_RE, BEAT_IM, DONE} state_t;

   localparam logic [ADDR_SIZE-1:0] ADDR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic [ADDR_SIZE-1:0]   base_q, base_d;
   logic [NUMBER_SIZE-1:0] wim_q, wim_d;
   logic                   req_q, req_d;
   logic                   we_q, we_d;
   logic [ADDR_SIZE-1:0]   addr_q, addr_d;
   logic [NUMBER_SIZE-1:0] wdata_q, wdata_d;
   logic [NUMBER_SIZE-1:0] rre_q, rre_d;
   logic [NUMBER_SIZE-1:0] rim_q, rim_d;
   logic                   timeout;

`ifdef MEM_PORT_TIMEOUT_EN
   logic [7:0] wd_q, wd_d;
   logic       err_q, err_d;

   // Watchdog: counts consecutive unacknowledged request cycles. The 255th
   // such cycle ends the access.
   always_comb begin
      wd_d    = 8'd0;
      timeout = 1'b0;
      if (req_q && !mem_ack) begin
         if (wd_q == 8'd254) timeout = 1'b1;
         else                wd_d    = wd_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q  <= 8'd0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      wim_d   = wim_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rre_d   = rre_q;
      rim_d   = rim_q;
`ifdef MEM_PORT_TIMEOUT_EN
      err_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = BEAT_RE;
               base_d  = {addr_hi, addr_lo};
               wim_d   = wdata_im;
               req_d   = 1'b1;
               we_d    = is_store;
               addr_d  = {addr_hi, addr_lo};
               wdata_d = wdata_re;
            end
         end
         BEAT_RE: begin
            if (mem_ack) begin
               if (!we_q) rre_d = mem_rdata;
               // req stays high; the second beat is presented immediately
               state_d = BEAT_IM;
               addr_d  = base_q + ADDR_ONE;
               wdata_d = wim_q;
            end else if (timeout) begin
               state_d = DONE;
               req_d   = 1'b0;
               we_d    = 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
               err_d   = 1'b1;
`endif
            end
         end
         BEAT_IM: begin
            if (mem_ack || timeout) begin
               if (mem_ack && !we_q) rim_d = mem_rdata;
               state_d = DONE;
               req_d   = 1'b0;
               we_d    = 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
               err_d   = !mem_ack;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         wim_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rre_q   <= '0;
         rim_q   <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         wim_q   <= wim_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rre_q   <= rre_d;
         rim_q   <= rim_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata_re  = rre_q;
   assign rdata_im  = rim_q;

endmodule

// File: tb/tb_complex_mem_port.sv
module tb_complex_mem_port;

   logic        clk = 1'b0;
   logic        rst, start, is_store;
   logic [7:0]  addr_hi, addr_lo, wdata_re, wdata_im;
   logic        busy, done, err;
   logic [7:0]  rdata_re, rdata_im;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   complex_mem_port #(.NUMBER_SIZE(8), .ADDR_SIZE(16)) dut (
      .clk(clk), .rst(rst), .start(start), .is_store(is_store),
      .addr_hi(addr_hi), .addr_lo(addr_lo), .wdata_re(wdata_re), .wdata_im(wdata_im),
      .busy(busy), .done(done), .err(err), .rdata_re(rdata_re), .rdata_im(rdata_im),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {logic [15:0] a; logic we; logic [7:0] d;} beat_t;
   typedef struct {logic [7:0] re; logic [7:0] im; logic er;} res_t;

   beat_t beat_q[$];
   res_t  res_q[$];
   logic [7:0] ref_mem [65536];   // model view of memory
   logic [7:0] bus_mem [65536];   // memory seen by the bus responder
   logic [7:0] last_re, last_im;  // model of the rdata registers
   int checks = 0, failures = 0;
   int fixed_wait = 0;            // <0: random waits 0..3 per beat

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bus responder: decides ack for the current cycle after outputs settle.
   initial begin : responder
      int wcnt, tgt;
      mem_ack = 1'b0; mem_rdata = 8'h00; wcnt = 0; tgt = 0;
      forever begin
         @(posedge clk); #2;
         if (mem_req) begin
            if (wcnt < tgt) begin
               mem_ack = 1'b0; wcnt++;
            end else begin
               mem_ack = 1'b1;
               mem_rdata = bus_mem[mem_addr];
               if (mem_we) bus_mem[mem_addr] = mem_wdata;
               wcnt = 0;
               tgt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            end
         end else begin
            // ack noise while idle must be ignored by the DUT
            mem_ack = 1'($urandom_range(0, 1));
            mem_rdata = 8'($urandom);
            wcnt = 0;
            tgt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
         end
      end
   end

   // Monitor: pops expectations whenever a beat is accepted or done pulses.
   always @(negedge clk) begin : monitor
      beat_t b;
      res_t  r;
      if (!rst) begin
         if (mem_req && mem_ack) begin
            if (beat_q.size() == 0) chk("unexpected_beat", 32'(mem_addr), 32'hFFFFFFFF);
            else begin
               b = beat_q.pop_front();
               chk("beat_addr", 32'(mem_addr), 32'(b.a));
               chk("beat_we", 32'(mem_we), 32'(b.we));
               chk("beat_wdata", 32'(mem_wdata), 32'(b.d));
            end
         end
         if (done) begin
            if (res_q.size() == 0) chk("unexpected_done", 32'(done), 32'h0);
            else begin
               r = res_q.pop_front();
               chk("rdata_re", 32'(rdata_re), 32'(r.re));
               chk("rdata_im", 32'(rdata_im), 32'(r.im));
               chk("done_err", 32'(err), 32'(r.er));
               chk("busy_in_done", 32'(busy), 32'h1);
            end
         end else if (err) chk("err_without_done", 32'(err), 32'h0);
      end
   end

   // One access. exp_lat>0 checks edges from acceptance to done; pulse_at
   // re-asserts start mid-access; rst_at aborts the access with reset;
   // tmo expects a watchdog abort with no accepted beats.
   task automatic do_op(input logic [15:0] a, input bit st, input logic [7:0] re,
                        input logic [7:0] im, input int exp_lat, input int pulse_at,
                        input int rst_at, input bit tmo);
      int cyc;
      logic [15:0] a1;
      a1 = a + 16'd1;
      if (!tmo) begin
         beat_q.push_back('{a, st, re});
         beat_q.push_back('{a1, st, im});
         if (st) begin ref_mem[a] = re; ref_mem[a1] = im; end
         else begin last_re = ref_mem[a]; last_im = ref_mem[a1]; end
      end
      if (rst_at < 0) res_q.push_back('{last_re, last_im, tmo});
      addr_hi = a[15:8]; addr_lo = a[7:0]; is_store = st;
      wdata_re = re; wdata_im = im; start = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0; rst = 1'b0;
         if (rst_at >= 0 && cyc == rst_at + 1) begin
            chk("abort_req", 32'(mem_req), 32'h0);
            chk("abort_busy", 32'(busy), 32'h0);
            chk("abort_rdata", {16'h0, rdata_re, rdata_im}, 32'h0);
            beat_q.delete(); res_q.delete();
            last_re = 8'h00; last_im = 8'h00;
            repeat (4) @(posedge clk);
            #1;
            return;
         end
         if (cyc == pulse_at) begin
            start = 1'b1; addr_hi = 8'h99; addr_lo = 8'h99; is_store = 1'b1;
         end
         if (cyc == rst_at) rst = 1'b1;
      end while (!done && cyc < 400);
      start = 1'b0;
      if (!done) chk("done_timeout", 32'(cyc), 32'(exp_lat));
      else if (exp_lat > 0) chk("latency", 32'(cyc), 32'(exp_lat));
      @(posedge clk); #1;
      chk("idle_after_done", {30'h0, busy, err}, 32'h0);
   endtask

   initial begin
      logic [7:0] v;
      bit ok;
      for (int i = 0; i < 65536; i++) begin
         v = 8'($urandom); ref_mem[i] = v; bus_mem[i] = v;
      end
      rst = 1'b1; start = 1'b0; is_store = 1'b0;
      addr_hi = 8'h00; addr_lo = 8'h00; wdata_re = 8'h00; wdata_im = 8'h00;
      last_re = 8'h00; last_im = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_status", {29'h0, busy, done, err}, 32'h0);
      chk("reset_bus", {14'h0, mem_req, mem_we, mem_addr}, 32'h0);
      chk("reset_data", {8'h0, mem_wdata, rdata_re, rdata_im}, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // zero-wait load
      fixed_wait = 0;
      ref_mem[16'h1234] = 8'h05; bus_mem[16'h1234] = 8'h05;
      ref_mem[16'h1235] = 8'hFB; bus_mem[16'h1235] = 8'hFB;
      do_op(16'h1234, 1'b0, 8'h11, 8'h22, 3, -1, -1, 1'b0);
      chk("load_result", {16'h0, rdata_re, rdata_im}, 32'h05FB);

      // store with two wait cycles per beat
      fixed_wait = 2;
      do_op(16'h0040, 1'b1, 8'h7F, 8'h81, 7, -1, -1, 1'b0);
      chk("store_mem", {16'h0, bus_mem[16'h0040], bus_mem[16'h0041]}, 32'h7F81);

      // address wrap
      fixed_wait = 0;
      do_op(16'hFFFF, 1'b0, 8'h00, 8'h00, 3, -1, -1, 1'b0);

      // start while busy is ignored
      fixed_wait = 1;
      do_op(16'h2000, 1'b0, 8'h00, 8'h00, 5, 3, -1, 1'b0);
      chk("no_extra_beats", 32'(beat_q.size()), 32'h0);

      // randomized traffic
      fixed_wait = -1;
      for (int n = 0; n < 40; n++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         do_op(a, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 0, -1, -1, 1'b0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      // reset during the imaginary-beat wait
      fixed_wait = 3;
      ref_mem[16'h3000] = 8'hA5; bus_mem[16'h3000] = 8'hA5;
      do_op(16'h3000, 1'b0, 8'h00, 8'h00, 0, -1, 5, 1'b0);

      // memory that never acknowledges
      fixed_wait = 100000;
`ifdef MEM_PORT_TIMEOUT_EN
      do_op(16'h5000, 1'b0, 8'h00, 8'h00, 256, -1, -1, 1'b1);
`else
      addr_hi = 8'h50; addr_lo = 8'h00; is_store = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (!mem_req || done || err) ok = 1'b0;
         @(posedge clk); #1;
      end
      chk("hang_req_held", 32'(ok), 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("hang_reset", {29'h0, mem_req, busy, done}, 32'h0);
      last_re = 8'h00; last_im = 8'h00;
`endif

      // recovery
      fixed_wait = 0;
      do_op(16'h1234, 1'b0, 8'h00, 8'h00, 3, -1, -1, 1'b0);
      fixed_wait = -1;
      do_op(16'h0100, 1'b1, 8'h3C, 8'hC3, 0, -1, -1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("queues_drained", 32'(beat_q.size() + res_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/complex_mem_port.md
# complex_mem_port

Sequential load/store engine that consumes the 16-bit effective address produced by the execute stage's MEM_ACCESS operation (`{Out1,Out2}`). It moves one complex operand, the real byte and the imaginary byte, between the core and byte-wide data memory as two back-to-back bus beats under a req/ack handshake. It sits between the ALU output and the data memory. On loads, its result feeds writeback.

## Interface
Parameters:
- NUMBER_SIZE, 8, width of one real or imaginary component
- ADDR_SIZE, 16, memory address width; must equal 2*NUMBER_SIZE

Ports:
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  request one complex access; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load; captured with start
- addr_hi  in  NUMBER_SIZE  upper address byte (ALU Out1)
- addr_lo  in  NUMBER_SIZE  lower address byte (ALU Out2)
- wdata_re  in  NUMBER_SIZE  real component to store; captured with start
- wdata_im  in  NUMBER_SIZE  imaginary component to store; captured with start
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse, coincident with done
- rdata_re  out  NUMBER_SIZE  loaded real component
- rdata_im  out  NUMBER_SIZE  loaded imaginary component
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_SIZE  bus byte address
- mem_wdata  out  NUMBER_SIZE  bus write data
- mem_ack  in  1  beat accept; valid only while mem_req is high
- mem_rdata  in  NUMBER_SIZE  read data; valid in the same cycle as mem_ack

## Operation
- States: IDLE, BEAT_RE, BEAT_IM, DONE.
- IDLE: on a posedge with start=1, capture `{addr_hi,addr_lo}`, is_store, wdata_re and wdata_im, then go to BEAT_RE. If start=0, stay in IDLE.
- BEAT_RE: drive mem_req=1, mem_addr=base, mem_we=is_store, mem_wdata=wdata_re. On a posedge with mem_ack=1, capture mem_rdata into rdata_re (loads only), then go to BEAT_IM.
- BEAT_IM: drive mem_addr=base+1, computed modulo 2^ADDR_SIZE, so 0xFFFF wraps to 0x0000, and mem_wdata=wdata_im. On ack, capture into rdata_im (loads only), then go to DONE.
- DONE: done=1 for exactly one cycle, mem_req=0, then go to IDLE.
- mem_req, mem_addr, mem_we and mem_wdata are registered and held stable until the accepting ack edge.
- mem_ack while mem_req=0 is ignored.
- start while busy is ignored and not queued.
- rdata_re/rdata_im hold their values until the next load overwrites them. A store leaves them unchanged.
- Reset values: state=IDLE; busy, done, err, mem_req, mem_we = 0; mem_addr, mem_wdata, rdata_re, rdata_im = 0.
- rst asserted mid-access aborts at that edge: mem_req=0 next cycle, no done pulse, partial load data discarded (rdata registers reset to 0).

## Timing
- start accepted at edge e0. mem_req is high from the cycle after e0.
- Zero-wait memory (ack high in the first req cycle): beats complete at e1 and e2, done is high in the cycle after e2, and start can be accepted again at e4.
- Minimum start-to-done latency is 3 cycles. Each wait cycle (req high, ack low) adds 1 cycle.
- busy is high from the cycle after e0 through the DONE cycle inclusive.
- mem_req stays high across the BEAT_RE to BEAT_IM transition. mem_addr advances in the same cycle.

## Configuration
- MEM_PORT_TIMEOUT_EN defined:
  - An 8-bit watchdog counts consecutive cycles with mem_req=1 and mem_ack=0, and clears on each ack.
  - When the count reaches 255, the FSM drops mem_req, enters DONE, and asserts done and err together for one cycle.
  - rdata beats not completed keep their prior values.
- MEM_PORT_TIMEOUT_EN undefined:
  - No counter is present. The FSM waits indefinitely for ack.
  - err is tied to 0.

## Test plan
- Load, zero-wait: addr=0x1234, mem returns 0x05 then 0xFB. Expect mem_addr 0x1234 then 0x1235, mem_we=0, done 3 cycles after start, rdata_re=0x05, rdata_im=0xFB.
- Store, 2 wait cycles per beat: addr=0x0040, wdata 0x7F/0x81. Expect mem_we=1, mem_wdata 0x7F at 0x0040 then 0x81 at 0x0041, done at cycle 7, rdata unchanged.
- Wrap: load at addr=0xFFFF. Expect second beat at mem_addr=0x0000.
- Start while busy: pulse start again during BEAT_IM with addr=0x9999. Expect no effect; only the original two beats occur.
- rst asserted in the BEAT_IM wait state: next cycle mem_req=0, busy=0, no done pulse, rdata=0.
- With MEM_PORT_TIMEOUT_EN defined: hold mem_ack=0. Expect mem_req to drop after 255 wait cycles and done=err=1 for one cycle. Without the macro, mem_req stays high for at least 300 cycles and err stays 0.
